// File: rtl/fetch_controller.sv
// Instruction fetch/sequencing FSM: PC, instruction register, flag latch and branch resolution.
// Optional HALT on 16'hFFFF is built when FETCH_HALT_EN is defined.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_FETCH   | MemRd issued at MemAddr=PC
// ST_DECODE  | memory word captured into IR on the closing edge
// ST_EXECUTE | IR on Opcode; ALU op writes and latches Flags, branch resolves PC
// ST_HALT    | (FETCH_HALT_EN only) parked until Reset
module fetch_controller #(
  parameter int         PC_W  = 10,
  parameter logic [3:0] BR_OP = 4'hC
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  output logic [PC_W-1:0] MemAddr,
  output logic            MemRd,
  input  logic [15:0]     MemData,
  output logic [15:0]     Opcode,
  output logic            WrEn,
  output logic            Cin,
  input  logic [4:0]      Flags,
  output logic            Halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXECUTE} state_t;
`endif

  localparam int EXT_W = PC_W - 8;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir;
  logic [4:0]      flag_reg;
  logic            ir_ld, flag_ld, mem_rd_c, wr_en_c;
  logic            is_branch, taken, halt_word;
  logic [PC_W-1:0] disp;

  assign is_branch = (ir[15:12] == BR_OP);
  assign disp      = {{EXT_W{ir[7]}}, ir[7:0]};

`ifdef FETCH_HALT_EN
  assign halt_word = (ir == 16'hFFFF);
  assign Halted    = (state == ST_HALT);
`else
  assign halt_word = 1'b0;
  assign Halted    = 1'b0;
`endif

  // Condition codes read the flags latched by the last completed ALU instruction.
  always_comb begin
    taken = 1'b0;
    case (ir[11:8])
      4'd0:    taken = flag_reg[3];
      4'd1:    taken = ~flag_reg[3];
      4'd2:    taken = flag_reg[0];
      4'd3:    taken = ~flag_reg[0];
      4'd4:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_ld     = 1'b0;
    flag_ld   = 1'b0;
    mem_rd_c  = 1'b0;
    wr_en_c   = 1'b0;
    if (!Stall) begin
      case (state)
        ST_FETCH: begin
          mem_rd_c  = 1'b1;
          state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          ir_ld     = 1'b1;
          state_nxt = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_nxt = ST_FETCH;
          if (halt_word) begin
`ifdef FETCH_HALT_EN
            state_nxt = ST_HALT;
`endif
          end else if (is_branch) begin
            pc_nxt = taken ? pc + disp : pc + PC_W'(1);
          end else begin
            wr_en_c = 1'b1;
            flag_ld = 1'b1;
            pc_nxt  = pc + PC_W'(1);
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir       <= 16'h0000;
      flag_reg <= 5'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_ld)   ir       <= MemData;
      if (flag_ld) flag_reg <= Flags;
    end
  end

  // Strobes are masked by Reset so nothing fires while reset is held.
  assign MemRd   = mem_rd_c & Reset;
  assign WrEn    = wr_en_c & Reset;
  assign MemAddr = pc;
  assign Opcode  = ir;
  assign Cin     = flag_reg[0];

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: instruction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized programs.
module tb_fetch_controller;
  localparam int PC_W = 10;
  localparam int DEPTH = 1 << PC_W;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Stall = 1'b0;
  logic [4:0]      Flags = 5'd0;
  logic [15:0]     MemData;
  logic [PC_W-1:0] MemAddr;
  logic            MemRd, WrEn, Cin, Halted;
  logic [15:0]     Opcode;

  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] rdata = 16'h0000;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  fetch_controller #(.PC_W(PC_W), .BR_OP(4'hC)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemData(MemData), .Opcode(Opcode), .WrEn(WrEn), .Cin(Cin), .Flags(Flags),
    .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // synchronous instruction memory: data one cycle after MemRd, held otherwise
  always @(posedge Clk) if (MemRd) rdata <= mem[MemAddr];
  assign MemData = rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    case (c)
      4'd0:    return f[3];
      4'd1:    return !f[3];
      4'd2:    return f[0];
      4'd3:    return !f[0];
      4'd4:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int br_target(input int pc, input logic [7:0] d);
    int s;
    s = d[7] ? int'(d) - 256 : int'(d);
    return (pc + s + DEPTH) % DEPTH;
  endfunction

  function automatic bit halt_word(input logic [15:0] w);
`ifdef FETCH_HALT_EN
    return w == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // m_step counts cycles spent in the current instruction: 0 fetch, 1 decode, 2 execute
  int          m_pc = 0;
  int          m_step = 0;
  logic [15:0] m_ir = 16'h0000;
  logic [4:0]  m_flags = 5'd0;
  bit          m_halt = 1'b0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_pc <= 0; m_step <= 0; m_ir <= 16'h0000; m_flags <= 5'd0; m_halt <= 1'b0;
    end else if (!m_halt && !Stall) begin
      if (m_step == 0) m_step <= 1;
      else if (m_step == 1) begin
        m_ir   <= mem[m_pc];
        m_step <= 2;
      end else begin
        m_step <= 0;
        if (halt_word(m_ir)) m_halt <= 1'b1;
        else if (m_ir[15:12] == 4'hC)
          m_pc <= cond_ok(m_ir[11:8], m_flags) ? br_target(m_pc, m_ir[7:0]) : (m_pc + 1) % DEPTH;
        else begin
          m_flags <= Flags;
          m_pc    <= (m_pc + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("memaddr", 32'(MemAddr), m_pc);
      check("memrd", 32'(MemRd), 32'(Reset && !m_halt && m_step == 0 && !Stall));
      check("wren", 32'(WrEn), 32'(Reset && !m_halt && m_step == 2 && !Stall &&
                                   m_ir[15:12] != 4'hC && !halt_word(m_ir)));
      check("opcode", 32'(Opcode), 32'(m_ir));
      check("cin", 32'(Cin), 32'(m_flags[0]));
      check("halted", 32'(Halted), 32'(m_halt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset();
    Reset = 1'b0;
    Stall = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < DEPTH; i++) mem[i] = w;
  endtask

  // After this returns we are inside cycle 1 (first FETCH).
  task automatic release_reset();
    Reset = 1'b1;
    #1;
  endtask

  int cnt_rd, cnt_wr;

  initial begin
    fill(16'h0001);
    tick();
    cmp_en = 1'b1;

    // 1: reset and first fetch
    hold_reset();
    check("rst_opcode", 32'(Opcode), 32'h0);
    check("rst_memrd", 32'(MemRd), 32'h0);
    fill(16'h0001); mem[0] = 16'h0153; Flags = 5'd0;
    release_reset();
    check("t1_memrd", 32'(MemRd), 32'h1);
    check("t1_addr0", 32'(MemAddr), 32'h0);
    ticks(2);
    check("t1_opcode", 32'(Opcode), 32'h0153);
    check("t1_wren", 32'(WrEn), 32'h1);
    tick();
    check("t1_addr1", 32'(MemAddr), 32'h1);

    // 2: taken / not-taken EQ branch at PC=5
    for (int z = 1; z >= 0; z--) begin
      hold_reset();
      fill(16'h0001); mem[5] = 16'hC0FE; Flags = (z != 0) ? 5'b01000 : 5'b00000;
      release_reset();
      ticks(17);
      check("t2_opcode", 32'(Opcode), 32'hC0FE);
      check("t2_wren", 32'(WrEn), 32'h0);
      tick();
      check("t2_target", 32'(MemAddr), (z != 0) ? 32'd3 : 32'd6);
    end

    // 3: carry latch and CS branch at PC=10
    hold_reset();
    fill(16'h0001); mem[10] = 16'hC203; Flags = 5'b00001;
    release_reset();
    ticks(2);
    check("t3_cin0", 32'(Cin), 32'h0);
    ticks(3);
    check("t3_cin1", 32'(Cin), 32'h1);
    ticks(27);
    check("t3_opcode", 32'(Opcode), 32'hC203);
    tick();
    check("t3_target", 32'(MemAddr), 32'd13);

    // 4: wrap-around at PC=1023 (reached by UC branch -1 from 0)
    for (int k = 0; k < 2; k++) begin
      hold_reset();
      fill(16'h0001); mem[0] = 16'hC4FF; mem[DEPTH-1] = (k == 0) ? 16'h0001 : 16'hC402;
      Flags = 5'd0;
      release_reset();
      ticks(3);
      check("t4_at1023", 32'(MemAddr), 32'd1023);
      ticks(3);
      check("t4_wrap", 32'(MemAddr), (k == 0) ? 32'd0 : 32'd1);
    end

    // 5: four stalled DECODE cycles, then reset during EXECUTE
    hold_reset();
    fill(16'h0001); Flags = 5'd0;
    release_reset();
    cnt_rd = int'(MemRd); cnt_wr = int'(WrEn);
    tick(); Stall = 1'b1; #1;
    cnt_rd += int'(MemRd); cnt_wr += int'(WrEn);
    for (int i = 0; i < 3; i++) begin
      tick(); cnt_rd += int'(MemRd); cnt_wr += int'(WrEn);
    end
    tick(); Stall = 1'b0; #1;
    cnt_rd += int'(MemRd); cnt_wr += int'(WrEn);
    tick();
    cnt_rd += int'(MemRd); cnt_wr += int'(WrEn);
    check("t5_wren_late", 32'(WrEn), 32'h1);
    check("t5_rd_pulses", 32'(cnt_rd), 32'd1);
    check("t5_wr_pulses", 32'(cnt_wr), 32'd1);
    tick();
    check("t5_next", 32'(MemAddr), 32'd1);
    ticks(2);
    check("t5_exec_wren", 32'(WrEn), 32'h1);
    Reset = 1'b0; #1;
    check("t5_rst_wren", 32'(WrEn), 32'h0);
    check("t5_rst_addr", 32'(MemAddr), 32'h0);
    tick();
    release_reset();
    check("t5_restart_rd", 32'(MemRd), 32'h1);
    check("t5_restart_addr", 32'(MemAddr), 32'h0);

    // 6: 16'hFFFF at address 2
    hold_reset();
    fill(16'h0001); mem[2] = 16'hFFFF;
    release_reset();
    ticks(8);
    check("t6_opcode", 32'(Opcode), 32'hFFFF);
`ifdef FETCH_HALT_EN
    check("t6_wren", 32'(WrEn), 32'h0);
    tick();
    check("t6_halted", 32'(Halted), 32'h1);
    cnt_rd = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); cnt_rd += int'(MemRd);
    end
    check("t6_no_rd", 32'(cnt_rd), 32'd0);
    check("t6_still_halted", 32'(Halted), 32'h1);
`else
    check("t6_wren", 32'(WrEn), 32'h1);
    tick();
    check("t6_next_addr", 32'(MemAddr), 32'd3);
    check("t6_next_rd", 32'(MemRd), 32'h1);
    check("t6_halted", 32'(Halted), 32'h0);
`endif

    // random programs, stalls, flags and resets against the model
    hold_reset();
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] w;
      int r;
      r = $urandom_range(0, 15);
      w = 16'($urandom);
      if (r < 5) w = {4'hC, 4'($urandom_range(0, 7)), 8'($urandom)};
      else if (r == 15 && $urandom_range(0, 3) == 0) w = 16'hFFFF;
      else if (w[15:12] == 4'hC) w[15:12] = 4'h0;
      mem[i] = w;
    end
    release_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      Stall = ($urandom_range(0, 3) == 0);
      Flags = 5'($urandom);
      Reset = ($urandom_range(0, 299) != 0);
    end
    Reset = 1'b1;
    ticks(3);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch and sequencing block that drives the datapath's `Opcode` input. Holds the 10-bit program counter, reads 16-bit instruction words from synchronous instruction memory, and presents each word to the datapath for exactly one execute cycle with a register write strobe. Latches the ALU `Flags` and resolves conditional branches, supplying `Cin` from the latched carry.

## Interface

**Parameters**
- `PC_W`, default 10: program counter and memory address width.
- `BR_OP`, default 4'hC: value of `Opcode[15:12]` that marks a branch.

**Ports**
- `Clk`, input, 1: clock; all state changes on the rising edge.
- `Reset`, input, 1: reset, asynchronous and active-low.
- `Stall`, input, 1: holds the FSM in its current state.
- `MemAddr`, output, PC_W: instruction memory address; always equals PC.
- `MemRd`, output, 1: memory read strobe.
- `MemData`, input, 16: instruction word, valid 1 cycle after `MemRd`.
- `Opcode`, output, 16: instruction register, routed to the datapath.
- `WrEn`, output, 1: register-file write enable; the datapath gates its decoded register enable with this signal.
- `Cin`, output, 1: latched carry flag, `FlagReg[0]`.
- `Flags`, input, 5: ALU flags. Bit 0 is C, 1 is L, 2 is F, 3 is Z, 4 is N.
- `Halted`, output, 1: high in HALT.

## Operation

- **Reset low (async):** PC=0, state=FETCH, IR=16'h0000, FlagReg=0. While `Reset` is low, `MemRd`=0, `WrEn`=0, `Halted`=0, `Opcode`=0, `Cin`=0.
- **FETCH:** `MemRd`=1 when `Stall`=0. Next state is DECODE.
- **DECODE:** IR <= `MemData`. Next state is EXECUTE.
- **EXECUTE:** `Opcode`=IR.
  - Non-branch instruction: `WrEn`=1, FlagReg <= `Flags` at the closing edge, PC <= PC+1.
  - Branch (`IR[15:12]`==BR_OP): `WrEn`=0 and FlagReg is unchanged.
  - Branch condition `IR[11:8]`, evaluated on FlagReg:
    - 0 = EQ (Z=1)
    - 1 = NE (Z=0)
    - 2 = CS (C=1)
    - 3 = CC (C=0)
    - 4 = UC (always)
    - 5–15 = never taken
  - Taken branch: PC <= PC + sign_extend(`IR[7:0]`). Not taken: PC <= PC+1.
  - Next state is FETCH.
- **Arithmetic:** all PC arithmetic is modulo 2^PC_W. PC wraps 1023→0. A branch with displacement 8'h00 loops on itself.
- **Stall=1:** state, PC, IR and FlagReg hold. `MemRd`=0 and `WrEn`=0 are forced. `Opcode` keeps IR.
- **Reset mid-instruction:** the instruction is abandoned with no register write, and the FSM restarts at FETCH with PC=0.

## Timing

- Non-stalled CPI is exactly 3 cycles: FETCH, DECODE, EXECUTE.
- The first `MemRd` occurs in the cycle after `Reset` deasserts, at address 0.
- `MemData` is sampled at the rising edge ending DECODE, i.e. 1 cycle after `MemRd`.
- `WrEn` is high for exactly one cycle per non-branch instruction.
- The datapath result is written on the edge that ends EXECUTE. Flags are latched on that same edge.
- A branch sees flags from the most recent completed non-branch instruction.
- `Stall` asserted in any state adds exactly one cycle per stalled cycle. Stall does not duplicate `MemRd` or `WrEn` pulses.

## Configuration

- **`FETCH_HALT_EN` defined:**
  - In EXECUTE, IR==16'hFFFF gives `WrEn`=0 and next state HALT. PC is not incremented.
  - HALT: `Halted`=1, `MemRd`=0, `WrEn`=0. The state is left only by `Reset`.
- **`FETCH_HALT_EN` undefined:**
  - 16'hFFFF executes as an ordinary ALU instruction (`WrEn`=1).
  - `Halted` is tied to 0 and no HALT state exists.

## Test plan

1. **Reset and fetch.** Release `Reset`, memory[0]=16'h0153.
   - Required: `MemRd` at cycle 1 with `MemAddr`=0.
   - Required: `Opcode`=16'h0153 and `WrEn`=1 in cycle 3.
   - Required: `MemAddr`=1 in cycle 4.
2. **Taken branch.** Flags input 5'b01000 (Z=1) during a non-branch EXECUTE, then IR=16'hC0FE at PC=5.
   - Required: `WrEn`=0 and next `MemAddr`=3.
   - Repeat with Z=0: next `MemAddr`=6.
3. **Carry forwarding.** Flags=5'b00001 latched.
   - Required: `Cin`=1 during the next instruction's EXECUTE.
   - A branch 16'hC203 at PC=10 goes to `MemAddr`=13.
4. **Wrap-around.** PC=1023 with a non-branch instruction.
   - Required: next `MemAddr`=0.
   - UC branch 16'hC402 at PC=1023: next `MemAddr`=1.
5. **Stall and reset.** `Stall` high for 4 cycles during DECODE.
   - Required: completion delayed by exactly 4 cycles, one `MemRd` pulse, one `WrEn` pulse.
   - `Reset` pulsed low during EXECUTE: `WrEn` drops immediately, restart at `MemAddr`=0.
6. **`FETCH_HALT_EN` defined.** memory[2]=16'hFFFF.
   - Required: `Halted`=1 from the cycle after that EXECUTE onward.
   - Required: no further `MemRd` until `Reset`.
   - Undefined: `WrEn`=1 for the same word, then fetch of address 3.
